// File: rtl/barrel_shifter_right_seq.sv
// barrel_shifter_right_seq
// -----------------------------------------------------------------------------
// Multi-cycle N-bit right rotator. It resolves one log2 stage per clock: stage k
// rotates the working word right by 2^k when shiftAmount[k] is set. Operands and
// results move through valid/ready handshakes. A result appears logN clocks after
// the operand is accepted, with no fast path for shiftAmount == 0.
//
// Optional feature (macro BARREL_SHIFTER_ARITH_EN):
//   Adds the isArith input, which is latched together with the operand. When
//   isArith is set, every enabled stage does an arithmetic right shift. Vacated
//   MSBs are then filled with the latched operand MSB instead of rotated bits.
//   With the macro undefined there is no isArith port and the block always
//   rotates.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   inValid      in   operand valid
//   inReady      out  block can accept an operand (IDLE)
//   a            in   [N-1:0] operand
//   shiftAmount  in   [logN-1:0] right-rotate amount
//   isArith      in   arithmetic-shift select (only with BARREL_SHIFTER_ARITH_EN)
//   outValid     out  result valid (DONE)
//   outReady     in   consumer accepts the result
//   shifted      out  [N-1:0] result, meaningful only while outValid is high
// -----------------------------------------------------------------------------
module barrel_shifter_right_seq #(
  parameter int unsigned N    = 32,
  localparam int unsigned logN = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inValid,
  output logic            inReady,
  input  logic [N-1:0]    a,
  input  logic [logN-1:0] shiftAmount,
`ifdef BARREL_SHIFTER_ARITH_EN
  input  logic            isArith,
`endif
  output logic            outValid,
  input  logic            outReady,
  output logic [N-1:0]    shifted
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  // Counter value of the final stage; its edge moves the block to DONE.
  localparam logic [logN-1:0] LastCnt = logN'(logN - 1);

  state_e          state_q, state_d;
  logic [N-1:0]    data_q, data_d;
  logic [logN-1:0] amt_q, amt_d;
  logic [logN-1:0] cnt_q, cnt_d;
  logic [N-1:0]    result_q, result_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;

`ifdef BARREL_SHIFTER_ARITH_EN
  logic            arith_q, arith_d;
  logic            sign_q, sign_d;
`endif

  // ---------------------------------------------------------------------------
  // Single shared stage datapath. The stage distance is 2^cnt_q, so there is
  // only one N-wide rotate per cycle and never a full logN-level mux tree.
  // ---------------------------------------------------------------------------
  int unsigned     stage_sh;
  logic [N-1:0]    stage_shr;
  logic [N-1:0]    stage_rot;
  logic [N-1:0]    stage_res;

  always_comb begin
    stage_sh  = 32'd1 << cnt_q;
    stage_shr = data_q >> stage_sh;
    // stage_sh never exceeds N/2, so the left shift below is always non-empty.
    stage_rot = stage_shr | (data_q << (N - stage_sh));
`ifdef BARREL_SHIFTER_ARITH_EN
    if (arith_q) begin
      // Fill vacated MSBs with the original sign rather than wrapped bits.
      stage_res = sign_q ? (stage_shr | ~({N{1'b1}} >> stage_sh)) : stage_shr;
    end else begin
      stage_res = stage_rot;
    end
`else
    stage_res = stage_rot;
`endif
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    amt_d    = amt_q;
    cnt_d    = cnt_q;
    result_d = result_q;
`ifdef BARREL_SHIFTER_ARITH_EN
    arith_d  = arith_q;
    sign_d   = sign_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (inValid) begin
          data_d  = a;
          amt_d   = shiftAmount;
          cnt_d   = '0;
`ifdef BARREL_SHIFTER_ARITH_EN
          arith_d = isArith;
          sign_d  = a[N-1];
`endif
          state_d = StShift;
        end
      end

      StShift: begin
        if (amt_q[cnt_q]) begin
          data_d = stage_res;
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          // Capture the final word straight into the output register so that
          // shifted changes only when a new result becomes valid.
          result_d = amt_q[cnt_q] ? stage_res : data_q;
          state_d  = StDone;
        end
      end

      StDone: begin
        if (outReady) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Handshake flags are registered from the next state, so both outputs
    // come from flops and have no combinational path from the inputs.
    in_ready_d  = (state_d == StIdle);
    out_valid_d = (state_d == StDone);
  end

  // ---------------------------------------------------------------------------
  // State registers (synchronous reset; rst wins over any handshake)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      data_q      <= '0;
      amt_q       <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef BARREL_SHIFTER_ARITH_EN
      arith_q     <= 1'b0;
      sign_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      amt_q       <= amt_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef BARREL_SHIFTER_ARITH_EN
      arith_q     <= arith_d;
      sign_q      <= sign_d;
`endif
    end
  end

  assign inReady  = in_ready_q;
  assign outValid = out_valid_q;
  assign shifted  = result_q;

endmodule

// File: tb/tb_barrel_shifter_right_seq.sv
// Directed self-checking bench for barrel_shifter_right_seq (N = 32).
module tb_barrel_shifter_right_seq;

  localparam int unsigned N    = 32;
  localparam int unsigned logN = 5;

  logic            clk;
  logic            rst;
  logic            inValid;
  logic            inReady;
  logic [N-1:0]    a;
  logic [logN-1:0] shiftAmount;
  logic            outValid;
  logic            outReady;
  logic [N-1:0]    shifted;
`ifdef BARREL_SHIFTER_ARITH_EN
  logic            isArith;
`endif

  int unsigned n_checks;
  int unsigned n_errors;

  barrel_shifter_right_seq #(
    .N (N)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .inValid     (inValid),
    .inReady     (inReady),
    .a           (a),
    .shiftAmount (shiftAmount),
`ifdef BARREL_SHIFTER_ARITH_EN
    .isArith     (isArith),
`endif
    .outValid    (outValid),
    .outReady    (outReady),
    .shifted     (shifted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction: accept, measure latency, check result, drain.
  task automatic run_op(input string tag, input logic [N-1:0] op,
                        input logic [logN-1:0] amt, input logic [N-1:0] exp);
    int lat;
    int guard;
    guard = 0;
    while (!inReady && guard < 20) begin
      tick();
      guard++;
    end
    inValid     = 1'b1;
    a           = op;
    shiftAmount = amt;
    tick();
    inValid = 1'b0;
    lat     = 0;
    while (!outValid && lat < 20) begin
      tick();
      lat++;
    end
    check_eq({tag, "_latency"}, lat, 32'd5);
    check_eq({tag, "_value"}, shifted, exp);
    outReady = 1'b1;
    tick();
    outReady = 1'b0;
    check_eq({tag, "_drain_valid"}, {31'd0, outValid}, 32'd0);
  endtask

  initial begin
    int seen;
    int t_first;
    int t_second;
    logic [N-1:0] r_first;
    logic [N-1:0] r_second;

    n_checks    = 0;
    n_errors    = 0;
    rst         = 1'b1;
    inValid     = 1'b0;
    a           = '0;
    shiftAmount = '0;
    outReady    = 1'b0;
`ifdef BARREL_SHIFTER_ARITH_EN
    isArith     = 1'b0;
`endif

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    check_eq("rst_in_ready", {31'd0, inReady}, 32'd1);
    check_eq("rst_out_valid", {31'd0, outValid}, 32'd0);
    check_eq("rst_shifted", shifted, 32'h0000_0000);

    // Basic rotations
    run_op("rot1", 32'h0000_0001, 5'd1, 32'h8000_0000);
    run_op("rot4", 32'h1234_5678, 5'd4, 32'h8123_4567);
    run_op("rot0", 32'h1234_5678, 5'd0, 32'h1234_5678);
    run_op("rot8", 32'hDEAD_BEEF, 5'd8, 32'hEFDE_ADBE);
    run_op("rot31", 32'h8000_0001, 5'd31, 32'h0000_0003);

    // Backpressure: hold result for 3 cycles, a stray inValid must be ignored
    inValid     = 1'b1;
    a           = 32'h0000_000F;
    shiftAmount = 5'd4;
    tick();
    inValid = 1'b0;
    seen    = 0;
    while (!outValid && seen < 20) begin
      tick();
      seen++;
    end
    check_eq("bp_latency", seen, 32'd5);
    for (int i = 0; i < 3; i++) begin
      inValid     = (i == 1);
      a           = 32'hFFFF_FFFF;
      shiftAmount = 5'd1;
      tick();
      check_eq("bp_hold_valid", {31'd0, outValid}, 32'd1);
      check_eq("bp_hold_value", shifted, 32'hF000_0000);
      check_eq("bp_hold_in_ready", {31'd0, inReady}, 32'd0);
    end
    inValid  = 1'b0;
    outReady = 1'b1;
    tick();
    outReady = 1'b0;
    check_eq("bp_release_valid", {31'd0, outValid}, 32'd0);
    check_eq("bp_release_in_ready", {31'd0, inReady}, 32'd1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (outValid) seen++;
    end
    check_eq("bp_stray_ignored", seen, 32'd0);

    // Reset two cycles into SHIFT
    inValid     = 1'b1;
    a           = 32'h1234_5678;
    shiftAmount = 5'd3;
    tick();
    inValid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("midrst_in_ready", {31'd0, inReady}, 32'd1);
    check_eq("midrst_out_valid", {31'd0, outValid}, 32'd0);
    check_eq("midrst_shifted", shifted, 32'h0000_0000);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (outValid) seen++;
    end
    check_eq("midrst_no_result", seen, 32'd0);

    // rst and inValid on the same edge: operand must not be accepted
    rst         = 1'b1;
    inValid     = 1'b1;
    a           = 32'h0000_0001;
    shiftAmount = 5'd1;
    tick();
    rst     = 1'b0;
    inValid = 1'b0;
    check_eq("rst_vs_valid_in_ready", {31'd0, inReady}, 32'd1);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (outValid) seen++;
    end
    check_eq("rst_vs_valid_no_result", seen, 32'd0);

    // Back-to-back with outReady tied high and inValid held high
    outReady    = 1'b1;
    inValid     = 1'b1;
    a           = 32'hAAAA_AAAA;
    shiftAmount = 5'd1;
    tick();
    a           = 32'h8000_0001;
    shiftAmount = 5'd31;
    seen     = 0;
    t_first  = -1;
    t_second = -1;
    r_first  = '0;
    r_second = '0;
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (outValid) begin
        if (seen == 0) begin
          t_first = t;
          r_first = shifted;
        end else if (seen == 1) begin
          t_second = t;
          r_second = shifted;
        end
        seen++;
      end
    end
    inValid = 1'b0;
    check_eq("b2b_count", seen, 32'd2);
    check_eq("b2b_first_time", t_first, 32'd5);
    check_eq("b2b_first_value", r_first, 32'h5555_5555);
    check_eq("b2b_spacing", t_second - t_first, 32'd7);
    check_eq("b2b_second_value", r_second, 32'h0000_0003);
    tick();
    tick();
    outReady = 1'b0;
    check_eq("b2b_idle", {31'd0, inReady}, 32'd1);

`ifdef BARREL_SHIFTER_ARITH_EN
    isArith = 1'b1;
    run_op("arith31", 32'h8000_0000, 5'd31, 32'hFFFF_FFFF);
    run_op("arith4", 32'h8765_4321, 5'd4, 32'hF876_5432);
    run_op("arith_pos", 32'h7000_0000, 5'd4, 32'h0700_0000);
    isArith = 1'b0;
    run_op("arith_off", 32'h8000_0000, 5'd31, 32'h0000_0001);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
